// File: rtl/seq_prio_encoder_pkg.sv
// Shared definitions for the sequential priority encoder: the index-width
// helper and the selection-mode constants.
package seq_prio_encoder_pkg;

   localparam int MODE_FIXED = 0;   // highest set index wins
   localparam int MODE_RR    = 1;   // round-robin starting after the last grant

   // Smallest r with 2**r >= value; used to size the encoded index.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_prio_encoder_enc_pick.sv
// Combinational selector: picks one index from the candidate vector, either
// by fixed priority (highest index) or round-robin (first set bit above ptr,
// wrapping), and reports whether any / more than one candidate exists.
module enc_pick
   import seq_prio_encoder_pkg::*;
#(
   parameter  int N       = 8,
   parameter  int RR_MODE = MODE_FIXED,
   localparam int W       = clog2(N)
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] sel,
   output logic         any,
   output logic         multi
);

   // Select one candidate and flag the any/multi conditions.
   always_comb begin
      // NOTE: every output gets a default before any conditional write so no latch is inferred.
      sel   = '0;
      any   = |cand;
      multi = (cand & (cand - N'(1))) != '0;
      if (RR_MODE == MODE_RR) begin
         // Wrapped region (index <= ptr) is scanned first so that any hit
         // above ptr overrides it; each loop leaves its lowest hit in sel.
         for (int i = N - 1; i >= 0; i--)
            if (cand[i] && (i <= int'(ptr))) sel = W'(i);
         for (int i = N - 1; i >= 0; i--)
            if (cand[i] && (i > int'(ptr))) sel = W'(i);
      end else begin
         // Ascending scan: the last (highest) set bit is kept.
         for (int i = 0; i < N; i++)
            if (cand[i]) sel = W'(i);
      end
   end

endmodule

// File: rtl/seq_prio_encoder.sv
// Registered priority encoder: latches request lines as pending flags and
// presents one encoded index at a time on a valid/ready output channel.
module seq_prio_encoder
   import seq_prio_encoder_pkg::*;
#(
   parameter  int N       = 8,
   parameter  int RR_MODE = MODE_FIXED,
   localparam int W       = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_index,
   output logic         out_multi,
   output logic [N-1:0] pending_o,
   output logic         idle
);

   logic [N-1:0] r_pending;
   logic         r_out_valid;
   logic [W-1:0] r_out_index;
   logic         r_out_multi;
   logic [W-1:0] r_ptr;

   logic [N-1:0] w_cand;
   logic [W-1:0] w_sel;
   logic         w_any;
   logic         w_multi;
   logic         w_load;

   // New requests are visible in the same cycle they arrive.
   assign w_cand = r_pending | req;

   // Load whenever the output slot is free or being drained this cycle.
   assign w_load = (!r_out_valid || out_ready) && w_any && !flush;

   enc_pick #(
      .N       (N),
      .RR_MODE (RR_MODE)
   ) u_pick (
      .cand  (w_cand),
      .ptr   (r_ptr),
      .sel   (w_sel),
      .any   (w_any),
      .multi (w_multi)
   );

   // Pending flags, output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_out_multi <= 1'b0;
         r_ptr       <= W'(N - 1);
      end else if (flush) begin
         // Requests arriving in the flush cycle are dropped; ptr and index stay.
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_out_multi <= 1'b0;
      end else if (w_load) begin
         r_out_index <= w_sel;
         r_out_valid <= 1'b1;
         r_out_multi <= w_multi;
         r_pending   <= w_cand & ~(N'(1) << w_sel);
         if (RR_MODE == MODE_RR) r_ptr <= w_sel;
      end else begin
         r_pending <= w_cand;
         if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign out_multi = r_out_multi;
   assign pending_o = r_pending;
   assign idle      = (r_pending == '0) && !r_out_valid;

endmodule
